// File: rtl/bennett_sched_if.sv
// Handshake/bus bundle for bennett_sched; the scheduler takes the slave side.
// seq_count exists only when BENNETT_SCHED_CNT_EN is defined.
interface bennett_sched_if #(
  parameter int PHASES  = 4,
  parameter int NREQ    = 2,
  parameter int DWELL_W = 4
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [DWELL_W-1:0] dwell_cfg;
  logic               peak_hold;
  logic [NREQ-1:0]    grant;
  logic [OW-1:0]      owner;
  logic               busy;
  logic [PHASES-1:0]  clkp;
  logic [PHASES-1:0]  ramp;
  logic               mclk;
  logic               done;
`ifdef BENNETT_SCHED_CNT_EN
  logic [15:0]        seq_count;
`endif

  modport master (
    output req, dwell_cfg, peak_hold,
    input  grant, owner, busy, clkp, ramp, mclk, done
`ifdef BENNETT_SCHED_CNT_EN
    , input seq_count
`endif
  );

  modport slave (
    input  req, dwell_cfg, peak_hold,
    output grant, owner, busy, clkp, ramp, mclk, done
`ifdef BENNETT_SCHED_CNT_EN
    , output seq_count
`endif
  );
endinterface

// File: rtl/bennett_sched.sv
// Round-robin Bennett phase-clock sequencer: grant, rise, dwell at peak, fall, done; all outputs registered.
// No backpressure: a granted sequence always runs to DONE; BENNETT_SCHED_CNT_EN adds a DONE counter.
module bennett_sched #(
  parameter int PHASES  = 4,
  parameter int NREQ    = 2,
  parameter int DWELL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  bennett_sched_if.slave   bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = $clog2(PHASES);
  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);
  localparam logic [PHASES-1:0] PH_ONE = PHASES'(1);

  typedef enum logic [2:0] {IDLE, RISE, PEAK, FALL, DONE} state_t;

  state_t             state_q;
  logic [KW-1:0]      k_q;
  logic [DWELL_W-1:0] dwell_q, cnt_q;
  logic [OW-1:0]      ptr_q, owner_q;
  logic [NREQ-1:0]    grant_q;
  logic [PHASES-1:0]  clkp_q, ramp_q;
  logic               busy_q, mclk_q, done_q;
  logic [OW-1:0]      win_d, idx_d;
  logic               any_d;

  function automatic logic [PHASES-1:0] therm(input int n);
    return (PH_ONE << n) - PH_ONE;
  endfunction

  function automatic logic [PHASES-1:0] onehot(input int n);
    return PH_ONE << n;
  endfunction

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_d = '0;
    idx_d = '0;
    any_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx_d = OW'((int'(ptr_q) + i) % NREQ);
      if (!any_d && bus.req[idx_d]) begin
        any_d = 1'b1;
        win_d = idx_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      clkp_q  <= '0;
      ramp_q  <= '0;
      mclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (any_d) begin
          state_q <= RISE;
          grant_q <= GRANT_ONE << win_d;
          owner_q <= win_d;
          ptr_q   <= OW'((int'(win_d) + 1) % NREQ);
          dwell_q <= (bus.dwell_cfg == '0) ? DWELL_W'(1) : bus.dwell_cfg;
          k_q     <= '0;
          busy_q  <= 1'b1;
          clkp_q  <= '0;
          ramp_q  <= onehot(0);
        end
        RISE: if (k_q == KW'(PHASES - 1)) begin
          state_q <= PEAK;
          clkp_q  <= '1;
          ramp_q  <= '0;
          mclk_q  <= 1'b1;
          cnt_q   <= DWELL_W'(1);
        end else begin
          k_q    <= k_q + KW'(1);
          clkp_q <= therm(int'(k_q) + 1);
          ramp_q <= onehot(int'(k_q) + 1);
        end
        // cnt saturates at dwell so a long peak_hold cannot wrap it.
        PEAK: if (cnt_q >= dwell_q && !bus.peak_hold) begin
          state_q <= FALL;
          k_q     <= KW'(PHASES - 1);
          clkp_q  <= therm(PHASES - 1);
          ramp_q  <= onehot(PHASES - 1);
          mclk_q  <= 1'b0;
        end else if (cnt_q < dwell_q) begin
          cnt_q <= cnt_q + DWELL_W'(1);
        end
        FALL: if (k_q == '0) begin
          state_q <= DONE;
          clkp_q  <= '0;
          ramp_q  <= '0;
          done_q  <= 1'b1;
        end else begin
          k_q    <= k_q - KW'(1);
          clkp_q <= therm(int'(k_q) - 1);
          ramp_q <= onehot(int'(k_q) - 1);
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BENNETT_SCHED_CNT_EN
  logic [15:0] seq_count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                seq_count_q <= '0;
    else if (state_q == DONE) seq_count_q <= seq_count_q + 16'd1;
  end
  assign bus.seq_count = seq_count_q;
`endif

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.clkp  = clkp_q;
  assign bus.ramp  = ramp_q;
  assign bus.mclk  = mclk_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_bennett_sched.sv
// Bench for bennett_sched at PHASES=4, NREQ=2, DWELL_W=4: cycle table, grant scoreboard, corner sequences.
module tb_bennett_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bennett_sched_if #(.PHASES(4), .NREQ(2), .DWELL_W(4)) bus();
  bennett_sched #(.PHASES(4), .NREQ(2), .DWELL_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] g;
    logic       o;
    int         c;
  } gexp_t;
  gexp_t sbq[$];
  gexp_t e_m;

  typedef struct {
    logic [3:0] clkp;
    logic [3:0] ramp;
    logic       mclk;
    logic       done;
    logic       busy;
    logic [1:0] grant;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Invariants plus scoreboard pop on every grant.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("ramp_onehot0", 32'($onehot0(bus.ramp)), 1);
      chk("grant_onehot0", 32'($onehot0(bus.grant)), 1);
      chk("clkp_therm", (bus.clkp + 4'd1) & bus.clkp, 0);
      chk("ramp_clkp_overlap", bus.ramp & bus.clkp, 0);
      if (bus.grant != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("unexpected_grant", bus.grant, 0);
        end else begin
          e_m = sbq.pop_front();
          chk("grant", bus.grant, e_m.g);
          chk("owner", bus.owner, e_m.o);
          chk("grant_cycle", cyc, e_m.c);
        end
      end
    end
  end

  task automatic run_seq(input logic [1:0] r, input logic [3:0] dw, input int hold_n,
                         input logic [1:0] eg, input logic eo, input int exp_peak);
    int c0, pk, dc;
    bit seen;
    @(negedge clk);
    bus.req = r;
    bus.dwell_cfg = dw;
    bus.peak_hold = (hold_n > 0);
    c0 = cyc;
    sbq.push_back('{eg, eo, c0 + 1});
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    bus.dwell_cfg = ~dw;
    pk = 0;
    dc = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.mclk) begin
        pk++;
        bus.peak_hold = (pk < hold_n);
      end else begin
        bus.peak_hold = (hold_n > 0);
      end
      if (bus.done) begin
        seen = 1'b1;
        dc = cyc;
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("peak_len", pk, exp_peak);
    if (seen) chk("grant_to_done", dc - (c0 + 1), 8 + exp_peak);
    @(negedge clk);
    bus.peak_hold = 1'b0;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tbl[0]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[1]  = '{4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[2]  = '{4'b0011, 4'b0100, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[3]  = '{4'b0111, 4'b1000, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[5]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00};
    tbl[6]  = '{4'b0111, 4'b1000, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[7]  = '{4'b0011, 4'b0100, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[8]  = '{4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[9]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00};

    reset = 1'b1;
    bus.req = 2'b00;
    bus.dwell_cfg = 4'd0;
    bus.peak_hold = 1'b0;
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clkp", bus.clkp, 0);
    chk("rst_ramp", bus.ramp, 0);
    chk("rst_mclk_done", {bus.mclk, bus.done}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic sequence, dwell 2; req and dwell_cfg change right after grant.
    @(posedge clk);
    #1;
    bus.req = 2'b01;
    bus.dwell_cfg = 4'd2;
    sbq.push_back('{2'b01, 1'b0, cyc + 1});
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_clkp", i + 1), bus.clkp, tbl[i].clkp);
      chk($sformatf("v%0d_ramp", i + 1), bus.ramp, tbl[i].ramp);
      chk($sformatf("v%0d_mclk", i + 1), 32'(bus.mclk), 32'(tbl[i].mclk));
      chk($sformatf("v%0d_done", i + 1), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("v%0d_busy", i + 1), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_grant", i + 1), bus.grant, tbl[i].grant);
      if (i == 0) begin
        bus.req = 2'b00;
        bus.dwell_cfg = 4'd9;
      end
    end
    chk("t1_sb_drained", sbq.size(), 0);

    // Both requesters held: ptr is 1 after the first grant, so 10, 01, 10 every 12 cycles.
    bus.req = 2'b11;
    bus.dwell_cfg = 4'd2;
    c0 = cyc;
    sbq.push_back('{2'b10, 1'b1, c0 + 1});
    sbq.push_back('{2'b01, 1'b0, c0 + 13});
    sbq.push_back('{2'b10, 1'b1, c0 + 25});
    repeat (25) @(posedge clk);
    #1 bus.req = 2'b00;
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("t2_sb_drained", sbq.size(), 0);
    chk("t2_idle", 32'(bus.busy), 0);

    run_seq(2'b01, 4'd0, 0, 2'b01, 1'b0, 1);
    run_seq(2'b01, 4'd1, 5, 2'b01, 1'b0, 5);
    run_seq(2'b01, 4'd15, 0, 2'b01, 1'b0, 15);
    run_seq(2'b11, 4'd3, 0, 2'b10, 1'b1, 3);

    // Asynchronous reset while at the peak.
    @(negedge clk);
    bus.req = 2'b01;
    bus.dwell_cfg = 4'd4;
    sbq.push_back('{2'b01, 1'b0, cyc + 1});
    @(posedge clk);
    #1 bus.req = 2'b00;
    for (int i = 0; i < 20 && !bus.mclk; i++) @(negedge clk);
    chk("pre_rst_mclk", 32'(bus.mclk), 1);
    chk("pre_rst_clkp", bus.clkp, 4'b1111);
    #2 reset = 1'b1;
    #1;
    chk("arst_clkp", bus.clkp, 0);
    chk("arst_mclk", 32'(bus.mclk), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_ramp", bus.ramp, 0);
    chk("arst_grant_done", {bus.grant, bus.done}, 0);
    chk("arst_owner", bus.owner, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_seq(2'b11, 4'd2, 0, 2'b01, 1'b0, 2);
    run_seq(2'b10, 4'd2, 0, 2'b10, 1'b1, 2);

    chk("final_sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
